adc_scan_controller: RTL

Multi-channel conversion sequencer for the discrete ramp-compare ADC on the Basys-3. It generates the 8-bit sawtooth for the R-2R DAC and drives the analog mux select. It detects the comparator falling edge and captures the ramp code, then returns one result per enabled channel, round-robin, over a valid/ready stream. It sits between the board I/O pins (DAC bits, mux select, comparator input) and the display/UART consumers of conversion results.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_edge_sync.sv | 27 ++
 rtl/adc_scan_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ramp-compare ADC scan controller.
package adc_pkg;

  localparam int ADC_BITS    = 8;
  localparam int RAMP_STEPS  = 256;
  localparam int AVG_SAMPLES = 4;
  localparam int SUM_BITS    = ADC_BITS + $clog2(AVG_SAMPLES);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RAMP,
    ACCUM,
    OUTPUT
  } state_t;

endpackage

// File: rtl/adc_edge_sync.sv
// Two-flop synchronizer for the asynchronous comparator plus a falling-edge detector.
module adc_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic comparator_out,
  output logic comp_sync,
  output logic comp_fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta      <= 1'b0;
      comp_sync <= 1'b0;
      prev      <= 1'b0;
    end else begin
      meta      <= comparator_out;
      comp_sync <= meta;
      prev      <= comp_sync;
    end
  end

  assign comp_fall = prev & ~comp_sync;

endmodule

// File: rtl/adc_scan_controller.sv
// Round-robin ramp-compare ADC sequencer: DAC sawtooth, mux select, code capture, valid/ready results.
// Define ADC_SCAN_AVG_EN to average four back-to-back ramps per channel.
module adc_scan_controller
  import adc_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int RAMP_DIV      = 16,
  parameter int SETTLE_CYCLES = 256,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                comparator_out,
  output logic [ADC_BITS-1:0] sawtooth_out,
  output logic [CH_W-1:0]     mux_sel,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [ADC_BITS-1:0] result_data,
  output logic [CH_W-1:0]     result_ch
);

  localparam int DIV_W = $clog2(RAMP_DIV);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   mask;
  logic [DIV_W-1:0]    presc;
  logic [SET_W-1:0]    settle_cnt;
  logic [ADC_BITS-1:0] code;
  logic                captured;
  logic                comp_sync, comp_fall;
  logic                step_end, ramp_end, cap_now;
  logic [CH_W-1:0]     next_ch, first_ch;
  logic                has_next;

`ifdef ADC_SCAN_AVG_EN
  localparam int SAMP_W = $clog2(AVG_SAMPLES);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(AVG_SAMPLES - 1);
  logic [SUM_BITS-1:0] sum;
  logic [SAMP_W-1:0]   samp;
  logic [ADC_BITS-1:0] fin_code;
`endif

  adc_edge_sync u_edge_sync (
    .clk            (clk),
    .reset          (reset),
    .comparator_out (comparator_out),
    .comp_sync      (comp_sync),
    .comp_fall      (comp_fall)
  );

  assign busy     = (state != IDLE);
  assign step_end = (presc == DIV_LAST);
  assign ramp_end = step_end && (sawtooth_out == '1);
  // A comparator already low at step 0 never produces an edge; sample it late in the step once the synchronizer has settled.
  assign cap_now  = (state == RAMP) && !captured &&
                    (comp_fall || (sawtooth_out == '0 && step_end && !comp_sync));

`ifdef ADC_SCAN_AVG_EN
  assign fin_code = cap_now ? sawtooth_out : code;
`endif

  always_comb begin
    next_ch  = '0;
    first_ch = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && i > int'(mux_sel)) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
      if (ch_en[i]) first_ch = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start && |ch_en) state_nxt = SETTLE;
      SETTLE: if (settle_cnt == SET_LAST) state_nxt = RAMP;
      RAMP: begin
`ifdef ADC_SCAN_AVG_EN
        if (ramp_end && samp == SAMP_LAST) state_nxt = ACCUM;
`else
        if (ramp_end) state_nxt = OUTPUT;
`endif
      end
      ACCUM:  state_nxt = OUTPUT;
      OUTPUT: begin
        if (result_valid && result_ready)
          state_nxt = (has_next || (continuous && |ch_en)) ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask         <= '0;
      mux_sel      <= '0;
      presc        <= '0;
      settle_cnt   <= '0;
      sawtooth_out <= '0;
      code         <= '0;
      captured     <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_ch    <= '0;
`ifdef ADC_SCAN_AVG_EN
      sum          <= '0;
      samp         <= '0;
`endif
    end else begin
      case (state)
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (state_nxt == RAMP) begin
            presc    <= '0;
            code     <= '1;
            captured <= 1'b0;
          end
        end
        RAMP: begin
          if (cap_now) begin
            code     <= sawtooth_out;
            captured <= 1'b1;
          end
          presc <= step_end ? '0 : presc + 1'b1;
          if (step_end) sawtooth_out <= sawtooth_out + 1'b1;
`ifdef ADC_SCAN_AVG_EN
          if (ramp_end) begin
            sum      <= sum + SUM_BITS'(fin_code);
            samp     <= samp + 1'b1;
            code     <= '1;
            captured <= 1'b0;
          end
`endif
        end
        OUTPUT: begin
          if (!result_valid) begin
            result_valid <= 1'b1;
            result_ch    <= mux_sel;
`ifdef ADC_SCAN_AVG_EN
            result_data  <= sum[SUM_BITS-1 -: ADC_BITS];
`else
            result_data  <= code;
`endif
          end else if (result_ready) begin
            result_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (state != SETTLE && state_nxt == SETTLE) begin
        settle_cnt   <= '0;
        sawtooth_out <= '0;
`ifdef ADC_SCAN_AVG_EN
        sum          <= '0;
        samp         <= '0;
`endif
        if (state == OUTPUT && has_next) begin
          mux_sel <= next_ch;
        end else begin
          mask    <= ch_en;
          mux_sel <= first_ch;
        end
      end
    end
  end

endmodule
